// File: rtl/color_sample_scheduler.sv
// color_sample_scheduler: sequences a TCS-style colour sensor into a periodic, gain-corrected
// red-channel sample stream. Optional auto-gain stepping is enabled by defining COLOR_AUTO_GAIN_EN.
module color_sample_scheduler #(
  parameter logic [23:0] INTERVAL = 24'd100000,
  parameter logic [23:0] TIMEOUT  = 24'd2000000,
  parameter logic [15:0] SAT_HI   = 16'hE000,
  parameter logic [15:0] SAT_LO   = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [1:0]  cfg_gain,
  input  logic        cfg_reflective,
  input  logic        sensor_ready,
  input  logic [15:0] sensor_red,
  output logic        sensor_enable,
  output logic [1:0]  sensor_gain,
  output logic        sensor_measure,
  output logic        sensor_reflective,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [15:0] sample_data,
  output logic [1:0]  sample_gain,
  output logic        sample_clip,
  output logic        busy,
  output logic        timeout_err
);

`ifdef COLOR_AUTO_GAIN_EN
  localparam logic AUTO_GAIN = 1'b1;
`else
  localparam logic AUTO_GAIN = 1'b0;
`endif

  localparam logic [23:0] TMO_RELOAD  = TIMEOUT - 24'd1;
  localparam logic [23:0] IVAL_RELOAD = INTERVAL - 24'd1;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WAKE   = 4'd1,
    ARM    = 4'd2,
    MEAS   = 4'd3,
    WAITLO = 4'd4,
    WAITHI = 4'd5,
    EVAL   = 4'd6,
    OUT    = 4'd7,
    ERR    = 4'd8
  } state_t;

  state_t      state_r;
  logic [23:0] ival_r;
  logic [23:0] tmo_r;
  logic [1:0]  adj_r;
  logic        seen_r;
  logic [15:0] red_r;
  logic        step_dn_s;
  logic        step_up_s;

  // Gain-step decision for the captured reading; capped at three steps per sample
  always_comb begin
    step_dn_s = 1'b0;
    step_up_s = 1'b0;
    if (AUTO_GAIN && (adj_r != 2'd3)) begin
      step_dn_s = (red_r >= SAT_HI) && (sensor_gain != 2'd0);
      step_up_s = (red_r < SAT_LO) && (sensor_gain != 2'd3);
    end else begin
      step_dn_s = 1'b0;
      step_up_s = 1'b0;
    end
  end

  // Sequencer: state, interval/timeout counters and every registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      ival_r            <= 24'd0;
      tmo_r             <= 24'd0;
      adj_r             <= 2'd0;
      seen_r            <= 1'b0;
      red_r             <= 16'd0;
      sensor_enable     <= 1'b0;
      sensor_gain       <= 2'd0;
      sensor_measure    <= 1'b0;
      sensor_reflective <= 1'b0;
      sample_valid      <= 1'b0;
      sample_data       <= 16'd0;
      sample_gain       <= 2'd0;
      sample_clip       <= 1'b0;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      sensor_measure <= 1'b0;
      if (tmo_r != 24'd0) tmo_r <= tmo_r - 24'd1;
      // interval keeps running across gain steps so re-measures stay paced
      if ((state_r != IDLE) && (state_r != ERR) && (ival_r != 24'd0)) ival_r <= ival_r - 24'd1;

      case (state_r)
        IDLE: begin
          sensor_enable <= 1'b0;
          busy          <= 1'b0;
          if (run) begin
            sensor_gain       <= cfg_gain;
            sensor_reflective <= cfg_reflective;
            adj_r             <= 2'd0;
            timeout_err       <= 1'b0;
            sensor_enable     <= 1'b1;
            busy              <= 1'b1;
            ival_r            <= 24'd0;
            tmo_r             <= TMO_RELOAD;
            state_r           <= WAKE;
          end
        end
        WAKE: begin
          if (sensor_ready) begin
            tmo_r   <= TMO_RELOAD;
            state_r <= ARM;
          end else if (tmo_r == 24'd0) begin
            sensor_enable <= 1'b0;
            timeout_err   <= 1'b1;
            tmo_r         <= TMO_RELOAD;
            state_r       <= ERR;
          end
        end
        ARM: begin
          if (!run) begin
            sensor_enable <= 1'b0;
            busy          <= 1'b0;
            tmo_r         <= TMO_RELOAD;
            state_r       <= IDLE;
          end else if ((ival_r == 24'd0) && sensor_ready) begin
            sensor_measure <= 1'b1;
            ival_r         <= IVAL_RELOAD;
            tmo_r          <= TMO_RELOAD;
            state_r        <= MEAS;
          end
        end
        MEAS: begin
          tmo_r   <= TMO_RELOAD;
          state_r <= WAITLO;
        end
        WAITLO: begin
          if (!sensor_ready) begin
            tmo_r   <= TMO_RELOAD;
            state_r <= WAITHI;
          end else if (tmo_r == 24'd0) begin
            sensor_enable <= 1'b0;
            timeout_err   <= 1'b1;
            tmo_r         <= TMO_RELOAD;
            state_r       <= ERR;
          end
        end
        WAITHI: begin
          // red is taken one cycle after ready is seen so the front-end value has settled
          if (seen_r) begin
            red_r   <= sensor_red;
            seen_r  <= 1'b0;
            tmo_r   <= TMO_RELOAD;
            state_r <= EVAL;
          end else if (sensor_ready) begin
            seen_r <= 1'b1;
          end else if (tmo_r == 24'd0) begin
            sensor_enable <= 1'b0;
            timeout_err   <= 1'b1;
            tmo_r         <= TMO_RELOAD;
            state_r       <= ERR;
          end
        end
        EVAL: begin
          tmo_r <= TMO_RELOAD;
          if (!run) begin
            adj_r         <= 2'd0;
            sensor_enable <= 1'b0;
            busy          <= 1'b0;
            state_r       <= IDLE;
          end else if (step_dn_s) begin
            sensor_gain <= sensor_gain - 2'd1;
            adj_r       <= adj_r + 2'd1;
            state_r     <= WAKE;
          end else if (step_up_s) begin
            sensor_gain <= sensor_gain + 2'd1;
            adj_r       <= adj_r + 2'd1;
            state_r     <= WAKE;
          end else begin
            sample_data  <= red_r;
            sample_gain  <= sensor_gain;
            sample_clip  <= (red_r >= SAT_HI);
            sample_valid <= 1'b1;
            adj_r        <= 2'd0;
            state_r      <= OUT;
          end
        end
        OUT: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            tmo_r        <= TMO_RELOAD;
            if (run) begin
              state_r <= ARM;
            end else begin
              sensor_enable <= 1'b0;
              busy          <= 1'b0;
              state_r       <= IDLE;
            end
          end
        end
        ERR: begin
          sensor_enable <= 1'b0;
          timeout_err   <= 1'b1;
          if (!run) begin
            busy    <= 1'b0;
            tmo_r   <= TMO_RELOAD;
            state_r <= IDLE;
          end
        end
        default: begin
          sensor_enable <= 1'b0;
          sample_valid  <= 1'b0;
          busy          <= 1'b0;
          seen_r        <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_sample_scheduler.sv
// Bench for color_sample_scheduler: behavioural sensor model, vector table, randomized
// transactions against a rule-level reference, and hand sequences for timing corners.
module tb_color_sample_scheduler;
  localparam int INTERVAL = 100;
  localparam int LAT      = 20;
  localparam logic [15:0] SAT_HI = 16'hE000;
  localparam logic [15:0] SAT_LO = 16'h0400;
`ifdef COLOR_AUTO_GAIN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, run, cfg_reflective, sensor_ready, sample_ready;
  logic [1:0] cfg_gain;
  logic [15:0] sensor_red;
  logic sensor_enable, sensor_measure, sensor_reflective, sample_valid, sample_clip, busy, timeout_err;
  logic [1:0] sensor_gain, sample_gain;
  logic [15:0] sample_data;

  color_sample_scheduler #(.INTERVAL(24'd100), .TIMEOUT(24'd50), .SAT_HI(16'hE000), .SAT_LO(16'h0400)) dut (
    .clk(clk), .rst(rst), .run(run), .cfg_gain(cfg_gain), .cfg_reflective(cfg_reflective),
    .sensor_ready(sensor_ready), .sensor_red(sensor_red), .sensor_enable(sensor_enable),
    .sensor_gain(sensor_gain), .sensor_measure(sensor_measure), .sensor_reflective(sensor_reflective),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .sample_gain(sample_gain), .sample_clip(sample_clip), .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [15:0] red_by_gain [4];
  bit stuck_ready = 1'b0;
  int cyc = 0, meas_count = 0, last_meas = -1, last_gap = 0, viol = 0, meas_left = 0;
  int rdy_cyc = 0, valid_cyc = 0;
  logic [1:0] meas_gain = 2'd0;
  logic prev_valid = 1'b0;

  // Sensor front-end model plus protocol monitor, evaluated 1 time unit after each edge
  initial begin
    sensor_ready = 1'b0;
    sensor_red   = 16'd0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!busy) last_meas = -1;
      if (sensor_measure) begin
        meas_count++;
        if (!sensor_ready) viol++;
        if (last_meas >= 0) begin
          last_gap = cyc - last_meas;
          if (last_gap < INTERVAL) viol++;
        end
        last_meas = cyc;
      end
      if (!rst && meas_left > 0 && sensor_gain !== meas_gain) viol++;
      if (sample_valid && !prev_valid) valid_cyc = cyc;
      prev_valid = sample_valid;
      if (rst || !sensor_enable) begin
        sensor_ready = 1'b0;
        meas_left = 0;
      end else if (meas_left > 0) begin
        meas_left--;
        if (meas_left == 0) begin
          sensor_red = red_by_gain[meas_gain];
          sensor_ready = 1'b1;
          rdy_cyc = cyc;
        end
      end else if (sensor_measure && !stuck_ready) begin
        sensor_ready = 1'b0;
        meas_left = LAT;
        meas_gain = sensor_gain;
      end else begin
        sensor_ready = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {5'd0, sensor_enable, sensor_gain, sensor_measure, sensor_reflective, sample_valid,
            sample_data, sample_gain, sample_clip, busy, timeout_err};
  endfunction

  function automatic logic [15:0] pick_red();
    case ($urandom_range(0, 9))
      0: return 16'h03FF;
      1: return 16'h0400;
      2: return 16'hDFFF;
      3: return 16'hE000;
      4: return 16'hFFFF;
      5: return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  // Reference: apply the gain-stepping rules to the per-gain readings of the model
  task automatic ref_sample(input logic [1:0] g0, output logic [15:0] d, output logic [1:0] g,
                            output logic c, output int n);
    int gain = int'(g0);
    int adj = 0;
    bit done = 1'b0;
    logic [15:0] r = 16'd0;
    n = 0;
    while (!done) begin
      n++;
      r = red_by_gain[gain];
      if (AUTO && adj < 3 && r >= SAT_HI && gain > 0) begin gain--; adj++; end
      else if (AUTO && adj < 3 && r < SAT_LO && gain < 3) begin gain++; adj++; end
      else done = 1'b1;
    end
    d = r; g = 2'(gain); c = (r >= SAT_HI);
  endtask

  task automatic wait_valid(input string nm, output bit got);
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin tick(); got = sample_valid; end
    check({nm, "_valid"}, 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit idle = 1'b0;
    for (int n = 0; n < 1000 && !idle; n++) begin tick(); idle = !busy; end
    check({nm, "_idle"}, 32'(idle), 32'd1);
    if (idle) check({nm, "_off"}, 32'(sensor_enable), 32'd0);
    else begin rst = 1'b1; tick(); rst = 1'b0; end
  endtask

  task automatic do_sample(input string nm, input logic [1:0] g, input logic refl, input int stall,
                           input logic [15:0] ed, input logic [1:0] eg, input logic ec, input int en);
    bit got;
    cfg_gain = g; cfg_reflective = refl; sample_ready = 1'b0; meas_count = 0; run = 1'b1;
    wait_valid(nm, got);
    if (got) begin
      repeat (stall) tick();
      check({nm, "_hold"}, 32'(sample_valid), 32'd1);
      check({nm, "_data"}, 32'(sample_data), 32'(ed));
      check({nm, "_gain"}, 32'(sample_gain), 32'(eg));
      check({nm, "_clip"}, 32'(sample_clip), 32'(ec));
      check({nm, "_refl"}, 32'(sensor_reflective), 32'(refl));
      check({nm, "_nmeas"}, 32'(meas_count), 32'(en));
    end
    sample_ready = 1'b1; run = 1'b0;
    tick();
    sample_ready = 1'b0;
    wait_idle(nm);
  endtask

  typedef struct {
    logic [1:0] g; logic refl; logic [15:0] red;
    logic [15:0] ed; logic [1:0] eg; logic ec;
  } vec_t;

  initial begin
    vec_t tbl [7];
    bit got, stable;
    logic [15:0] ed; logic [1:0] eg; logic ec; int en;

    // readings chosen so that no gain step applies in either build
    tbl[0] = '{2'd2, 1'b0, 16'h1234, 16'h1234, 2'd2, 1'b0};
    tbl[1] = '{2'd0, 1'b1, 16'hE000, 16'hE000, 2'd0, 1'b1};
    tbl[2] = '{2'd0, 1'b0, 16'hDFFF, 16'hDFFF, 2'd0, 1'b0};
    tbl[3] = '{2'd3, 1'b1, 16'h03FF, 16'h03FF, 2'd3, 1'b0};
    tbl[4] = '{2'd0, 1'b1, 16'hFFFF, 16'hFFFF, 2'd0, 1'b1};
    tbl[5] = '{2'd1, 1'b0, 16'h0400, 16'h0400, 2'd1, 1'b0};
    tbl[6] = '{2'd3, 1'b0, 16'h0000, 16'h0000, 2'd3, 1'b0};

    rst = 1'b1; run = 1'b0; cfg_gain = 2'd0; cfg_reflective = 1'b0; sample_ready = 1'b0;
    for (int k = 0; k < 4; k++) red_by_gain[k] = 16'd0;
    repeat (3) tick();
    check("reset_outs", outs(), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 4; k++) red_by_gain[k] = tbl[i].red;
      do_sample($sformatf("vec%0d", i), tbl[i].g, tbl[i].refl, 2, tbl[i].ed, tbl[i].eg, tbl[i].ec, 1);
    end

    // Continuous run: exact measure spacing and valid latency
    for (int k = 0; k < 4; k++) red_by_gain[k] = 16'h1234;
    cfg_gain = 2'd2; cfg_reflective = 1'b0; sample_ready = 1'b1; meas_count = 0; run = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin tick(); got = (meas_count >= 3); end
    check("cont_3meas", 32'(got), 32'd1);
    check("cont_gap", 32'(last_gap), 32'd100);
    check("cont_vlat", 32'(valid_cyc - rdy_cyc), 32'd3);
    check("cont_data", 32'(sample_data), 32'h1234);
    check("cont_gain", 32'(sample_gain), 32'd2);
    check("cont_clip", 32'(sample_clip), 32'd0);
    run = 1'b0; sample_ready = 1'b0;
    wait_idle("cont");

    // Back-pressure: output held, no new measure until accepted
    for (int k = 0; k < 4; k++) red_by_gain[k] = 16'h5A5A;
    cfg_gain = 2'd1; sample_ready = 1'b0; meas_count = 0; run = 1'b1;
    wait_valid("stall", got);
    stable = 1'b1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (!sample_valid || sample_data !== 16'h5A5A) stable = 1'b0;
    end
    check("stall_hold", 32'(stable), 32'd1);
    check("stall_nomeas", 32'(meas_count), 32'd1);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    check("stall_drop", 32'(sample_valid), 32'd0);
    got = 1'b0;
    for (int n = 0; n < 5 && !got; n++) begin tick(); got = (meas_count == 2); end
    check("stall_remeas", 32'(got), 32'd1);
    run = 1'b0;
    wait_idle("stall");

    // Saturated at gain 3 and 2, usable at gain 1
    red_by_gain[0] = 16'h8000; red_by_gain[1] = 16'h8000;
    red_by_gain[2] = 16'hF000; red_by_gain[3] = 16'hF000;
    if (AUTO) do_sample("agdn", 2'd3, 1'b0, 0, 16'h8000, 2'd1, 1'b0, 3);
    else      do_sample("agdn", 2'd3, 1'b0, 0, 16'hF000, 2'd3, 1'b1, 1);

    // Always dark: step up to the cap
    for (int k = 0; k < 4; k++) red_by_gain[k] = 16'h0010;
    if (AUTO) do_sample("agup", 2'd0, 1'b1, 0, 16'h0010, 2'd3, 1'b0, 4);
    else      do_sample("agup", 2'd0, 1'b1, 0, 16'h0010, 2'd0, 1'b0, 1);

    // Timeout: front-end never drops ready after a measure
    for (int k = 0; k < 4; k++) red_by_gain[k] = 16'h1111;
    stuck_ready = 1'b1; cfg_gain = 2'd0; meas_count = 0; run = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); got = (meas_count == 1); end
    check("tmo_meas", 32'(got), 32'd1);
    repeat (45) tick();
    check("tmo_early", 32'(timeout_err), 32'd0);
    repeat (10) tick();
    check("tmo_flag", 32'(timeout_err), 32'd1);
    check("tmo_enable", 32'(sensor_enable), 32'd0);
    check("tmo_busy", 32'(busy), 32'd1);
    run = 1'b0;
    repeat (2) tick();
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    stuck_ready = 1'b0; run = 1'b1;
    tick();
    check("tmo_clear", 32'(timeout_err), 32'd0);
    check("tmo_rewake", 32'(sensor_enable), 32'd1);
    run = 1'b0;
    wait_idle("tmo");
    do_sample("tmo_restart", 2'd2, 1'b0, 0, 16'h1111, 2'd2, 1'b0, 1);

    // Reset while waiting for the reading
    for (int k = 0; k < 4; k++) red_by_gain[k] = 16'h2222;
    cfg_gain = 2'd3; cfg_reflective = 1'b1; sample_ready = 1'b0; meas_count = 0; run = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); got = (meas_count == 1); end
    repeat (8) tick();
    rst = 1'b1;
    #1;
    check("rst_async", outs(), 32'd0);
    tick();
    check("rst_outs2", outs(), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_wake_busy", 32'(busy), 32'd1);
    check("rst_wake_en", 32'(sensor_enable), 32'd1);
    wait_valid("rst_again", got);
    check("rst_again_data", 32'(sample_data), 32'h2222);
    check("rst_again_gain", 32'(sample_gain), 32'd3);
    sample_ready = 1'b1; run = 1'b0;
    tick();
    sample_ready = 1'b0;
    wait_idle("rst_again");

    // Randomized transactions against the rule-level reference
    for (int i = 0; i < 12; i++) begin
      logic [1:0] g;
      logic refl;
      int stall;
      for (int k = 0; k < 4; k++) red_by_gain[k] = pick_red();
      g = 2'($urandom_range(0, 3));
      refl = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 6);
      ref_sample(g, ed, eg, ec, en);
      do_sample($sformatf("rnd%0d", i), g, refl, stall, ed, eg, ec, en);
    end

    check("protocol_viol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
